alu_1bit: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/full_adder_1bit.sv | 20 ++
 rtl/alu_1bit.sv | 82 ++++++++
 tb/tb_alu_1bit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared ALU definitions used by the 1-bit ALU slice, the 16-bit ALU built from
// it, and the control unit that drives the opcode.
//   aluop_t : 2-bit operation select (AND / OR / ADD / XOR)
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_AND = 2'b00,
      ALU_OR  = 2'b01,
      ALU_ADD = 2'b10,
      ALU_XOR = 2'b11
   } aluop_t;

endpackage : alu_pkg

// File: rtl/full_adder_1bit.sv
// -----------------------------------------------------------------------------
// full_adder_1bit
// Purely combinational one-bit full adder.
//   x, y : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out (majority of x, y, ci)
// -----------------------------------------------------------------------------
module full_adder_1bit (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule : full_adder_1bit

// File: rtl/alu_1bit.sv
// -----------------------------------------------------------------------------
// alu_1bit
// Replicated bit cell of the 16-bit ALU. Each operand may be inverted, then the
// opcode selects AND, OR, full-add sum or XOR. Result and carry are registered.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, clears rez and cout
//   a, b    : operand bits
//   ainvert : complement operand A before use
//   binvert : complement operand B before use (subtract / NOR / NAND)
//   cin     : carry in from lower slice (or the +1 of a subtract on bit 0)
//   aluop   : 00 AND, 01 OR, 10 ADD, 11 XOR
//   cout    : registered adder carry-out
//   rez     : registered result bit
// -----------------------------------------------------------------------------
module alu_1bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       a,
   input  logic       b,
   input  logic       ainvert,
   input  logic       binvert,
   input  logic       cin,
   input  logic [1:0] aluop,
   output logic       cout,
   output logic       rez
);

   import alu_pkg::*;

   logic   w_ea;
   logic   w_eb;
   logic   w_sum;
   logic   w_carry;
   logic   w_next_rez;
   logic   w_next_cout;
   aluop_t w_op;
   logic   r_rez;
   logic   r_cout;

   assign w_ea = a ^ ainvert;
   assign w_eb = b ^ binvert;
   assign w_op = aluop_t'(aluop);

   // The adder runs for every opcode so the ripple chain between slices does
   // not depend on the operation being performed.
   full_adder_1bit u_fa (
      .x  (w_ea),
      .y  (w_eb),
      .ci (cin),
      .s  (w_sum),
      .co (w_carry)
   );

   always_comb begin
      w_next_rez = 1'b0;
      case (w_op)
         ALU_AND: w_next_rez = w_ea & w_eb;
         ALU_OR:  w_next_rez = w_ea | w_eb;
         ALU_ADD: w_next_rez = w_sum;
         ALU_XOR: w_next_rez = w_ea ^ w_eb;
         default: w_next_rez = 1'b0;
      endcase
   end

   // Carry is reported for logic ops too; upper levels simply ignore it.
   assign w_next_cout = w_carry;

   // ---- output register stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rez  <= 1'b0;
         r_cout <= 1'b0;
      end else begin
         r_rez  <= w_next_rez;
         r_cout <= w_next_cout;
      end
   end

   assign rez  = r_rez;
   assign cout = r_cout;

endmodule : alu_1bit

// File: tb/tb_alu_1bit.sv
module tb_alu_1bit;

   logic       clk;
   logic       rst;
   logic       a;
   logic       b;
   logic       ainvert;
   logic       binvert;
   logic       cin;
   logic [1:0] aluop;
   logic       cout;
   logic       rez;

   int n_vec;
   int n_fail;

   alu_1bit dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .ainvert (ainvert),
      .binvert (binvert),
      .cin     (cin),
      .aluop   (aluop),
      .cout    (cout),
      .rez     (rez)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       a;
      logic       b;
      logic       ai;
      logic       bi;
      logic       cin;
      logic [1:0] op;
      logic       exp_rez;
      logic       exp_cout;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   // Packed stimulus: {op[1:0], cin, bi, ai, b, a}
   task automatic drive(input logic [6:0] v);
      a       = v[0];
      b       = v[1];
      ainvert = v[2];
      binvert = v[3];
      cin     = v[4];
      aluop   = v[6:5];
   endtask

   // Reference: arithmetic count of ones for the adder, case table for logic.
   function automatic logic [1:0] model(input logic [6:0] v);
      logic ea, eb, r, c;
      int   total;
      ea    = v[0] ^ v[2];
      eb    = v[1] ^ v[3];
      total = int'(ea) + int'(eb) + int'(v[4]);
      c     = (total >= 2);
      case (v[6:5])
         2'b00:   r = ea && eb;
         2'b01:   r = ea || eb;
         2'b10:   r = (total % 2) == 1;
         default: r = (ea != eb);
      endcase
      return {c, r};
   endfunction

   initial begin
      logic [1:0] exp;
      logic [6:0] v;
      n_vec  = 0;
      n_fail = 0;

      vecs[0] = '{"inv_a_add", 1, 1, 1, 0, 0, 2'b10, 1, 0};
      vecs[1] = '{"and_10",    1, 0, 0, 0, 0, 2'b00, 0, 0};
      vecs[2] = '{"or_10",     1, 0, 0, 0, 0, 2'b01, 1, 0};
      vecs[3] = '{"xor_10",    1, 0, 0, 0, 0, 2'b11, 1, 0};
      vecs[4] = '{"sub_bit0",  0, 0, 0, 1, 1, 2'b10, 0, 1};
      vecs[5] = '{"nor",       0, 1, 1, 1, 0, 2'b00, 0, 0};
      vecs[6] = '{"nand",      0, 1, 1, 1, 0, 2'b01, 1, 0};
      vecs[7] = '{"and_carry", 1, 1, 0, 0, 0, 2'b00, 1, 1};

      // Reset held with inputs that would otherwise produce 1/1
      rst = 1'b1;
      drive(7'b10_1_0_0_1_1);
      #1;
      check("rst_immediate_rez", rez, 1'b0);
      check("rst_immediate_cout", cout, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_hold_rez", rez, 1'b0);
         check("rst_hold_cout", cout, 1'b0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_release_rez", rez, 1'b1);
      check("rst_release_cout", cout, 1'b1);

      // Asynchronous reset mid-cycle, away from any clock edge
      #2 rst = 1'b1;
      #1;
      check("rst_async_rez", rez, 1'b0);
      check("rst_async_cout", cout, 1'b0);
      @(posedge clk); #1;
      check("rst_async_hold_rez", rez, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_async_release_rez", rez, 1'b1);
      check("rst_async_release_cout", cout, 1'b1);

      // Directed table
      for (int i = 0; i < 8; i++) begin
         a       = vecs[i].a;
         b       = vecs[i].b;
         ainvert = vecs[i].ai;
         binvert = vecs[i].bi;
         cin     = vecs[i].cin;
         aluop   = vecs[i].op;
         @(posedge clk); #1;
         check({vecs[i].name, "_rez"}, rez, vecs[i].exp_rez);
         check({vecs[i].name, "_cout"}, cout, vecs[i].exp_cout);
      end

      // Exhaustive sweep with mid-cycle input disturbance
      for (int i = 0; i < 128; i++) begin
         v = 7'(i);
         drive(v);
         exp = model(v);
         @(posedge clk); #1;
         check($sformatf("exh_%0d_rez", i), rez, exp[0]);
         check($sformatf("exh_%0d_cout", i), cout, exp[1]);
         drive(~v);
         #2;
         check($sformatf("exh_%0d_hold_rez", i), rez, exp[0]);
         check($sformatf("exh_%0d_hold_cout", i), cout, exp[1]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_alu_1bit
